// File: rtl/cfg_loader_pkg.sv
// Shared types and width helpers for the configuration-chain loader.
package cfg_loader_pkg;

   // Loader sequencing states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Bits needed to hold any count in 0..max_val (never less than 1).
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/cfg_word_serializer.sv
// Word-to-bit serializer: holds the current word, accepts the next one
// without a bubble, and presents one chain bit per enabled cycle.
module cfg_word_serializer
   import cfg_loader_pkg::*;
#(
   parameter int WORD = 32
) (
   input  logic            config_clk,
   input  logic            config_reset,
   input  logic            enable,       // loader is in SHIFT
   input  logic            clear,        // drop any held bits
   input  logic            final_bit,    // next shift is the last one of the load
   input  logic [WORD-1:0] word_data,
   input  logic            word_valid,
   output logic            word_ready,
   output logic            cfg_bit,
   output logic            cfg_shift_en
);

   localparam int                HELD_W    = cnt_width(WORD);
   localparam logic [HELD_W-1:0] HELD_FULL = HELD_W'(WORD);
   localparam logic [HELD_W-1:0] HELD_ONE  = HELD_W'(1);

   logic [WORD-1:0]   sreg;
   logic [HELD_W-1:0] held;
   logic              accept;

   assign cfg_shift_en = enable && (held != '0);
   assign cfg_bit      = cfg_shift_en & sreg[0];

   // Ready when empty, or when the last held bit leaves this cycle; never on
   // the final shift of a load so no word is swallowed after the chain fills.
   assign word_ready = enable && !(final_bit && cfg_shift_en) &&
                       ((held == '0) || ((held == HELD_ONE) && cfg_shift_en));
   assign accept     = word_valid && word_ready;

   // Shift register and held-bit count: load on accept, else shift out LSB.
   always_ff @(posedge config_clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (config_reset) begin
         // NOTE: sreg is a plain register, not a memory array, so it is reset
         // to keep stale configuration data off the chain after reset.
         sreg <= '0;
         held <= '0;
      end else if (clear) begin
         sreg <= '0;
         held <= '0;
      end else if (accept) begin
         sreg <= word_data;
         held <= HELD_FULL;
      end else if (cfg_shift_en) begin
         sreg <= sreg >> 1;
         held <= held - HELD_ONE;
      end
   end

endmodule

// File: rtl/cfg_chain_loader.sv
// Serial bitstream loader for the CGRA configuration chain: sequences one
// load of exactly CHAIN_BITS shifts and pulses done when it completes.
module cfg_chain_loader
   import cfg_loader_pkg::*;
#(
   parameter int CHAIN_BITS = 1024,
   parameter int WORD       = 32
) (
   input  logic            config_clk,
   input  logic            config_reset,
   input  logic            start,
   input  logic            abort,
   input  logic [WORD-1:0] word_data,
   input  logic            word_valid,
   output logic            word_ready,
   output logic            cfg_bit,
   output logic            cfg_shift_en,
   output logic            busy,
   output logic            done
);

   localparam int               CNT_W     = cnt_width(CHAIN_BITS);
   localparam logic [CNT_W-1:0] CHAIN_CNT = CNT_W'(CHAIN_BITS);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] remaining, remaining_nxt;
   logic             shifting;
   logic             final_bit;
   logic             ser_clear;

   assign shifting  = (state == SHIFT);
   assign final_bit = (remaining == CNT_ONE);

   cfg_word_serializer #(
      .WORD (WORD)
   ) u_serializer (
      .config_clk   (config_clk),
      .config_reset (config_reset),
      .enable       (shifting),
      .clear        (ser_clear),
      .final_bit    (final_bit),
      .word_data    (word_data),
      .word_valid   (word_valid),
      .word_ready   (word_ready),
      .cfg_bit      (cfg_bit),
      .cfg_shift_en (cfg_shift_en)
   );

   // State register and remaining-bit counter.
   always_ff @(posedge config_clk) begin
      if (config_reset) begin
         state     <= IDLE;
         remaining <= '0;
      end else begin
         state     <= state_nxt;
         remaining <= remaining_nxt;
      end
   end

   // Next-state, counter update and status outputs; abort overrides all.
   always_comb begin
      // NOTE: every signal written here gets a default first so no path leaves
      // it unassigned, which would otherwise infer a latch.
      state_nxt     = state;
      remaining_nxt = remaining;
      ser_clear     = 1'b0;
      busy          = 1'b0;
      done          = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt     = SHIFT;
               remaining_nxt = CHAIN_CNT;
               ser_clear     = 1'b1;
            end
         end
         SHIFT: begin
            busy = 1'b1;
            if (cfg_shift_en) begin
               remaining_nxt = remaining - CNT_ONE;
               if (final_bit) begin
                  // Chain is full: discard leftover bits of the last word.
                  state_nxt = DONE;
                  ser_clear = 1'b1;
               end
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (abort) begin
         state_nxt     = IDLE;
         remaining_nxt = '0;
         ser_clear     = 1'b1;
      end
   end

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Scoreboard bench for cfg_chain_loader: stimulus queues the expected serial
// bits and done cycles; a negedge monitor pops and compares them.
module tb_cfg_chain_loader;

   localparam int WORD = 32;
   localparam int BITS = 36;

   logic            config_clk   = 1'b0;
   logic            config_reset = 1'b1;
   logic            start        = 1'b0;
   logic            abort        = 1'b0;
   logic [WORD-1:0] word_data    = '0;
   logic            word_valid   = 1'b0;
   logic            word_ready, cfg_bit, cfg_shift_en, busy, done;

   logic            start32      = 1'b0;
   logic            abort32      = 1'b0;
   logic [WORD-1:0] word_data32  = '0;
   logic            word_valid32 = 1'b0;
   logic            ready32, bit32, sen32, busy32, done32;

   int   n_vec  = 0;
   int   n_fail = 0;
   int   cyc    = 0;
   int   gap_cnt = 0;
   logic bit_q[$];
   int   done_q[$];

   cfg_chain_loader #(.CHAIN_BITS(BITS), .WORD(WORD)) dut (
      .config_clk   (config_clk),
      .config_reset (config_reset),
      .start        (start),
      .abort        (abort),
      .word_data    (word_data),
      .word_valid   (word_valid),
      .word_ready   (word_ready),
      .cfg_bit      (cfg_bit),
      .cfg_shift_en (cfg_shift_en),
      .busy         (busy),
      .done         (done)
   );

   cfg_chain_loader #(.CHAIN_BITS(32), .WORD(WORD)) dut32 (
      .config_clk   (config_clk),
      .config_reset (config_reset),
      .start        (start32),
      .abort        (abort32),
      .word_data    (word_data32),
      .word_valid   (word_valid32),
      .word_ready   (ready32),
      .cfg_bit      (bit32),
      .cfg_shift_en (sen32),
      .busy         (busy32),
      .done         (done32)
   );

   always #5 config_clk = ~config_clk;

   always @(posedge config_clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge config_clk);
      #1;
   endtask

   // Monitor: every enabled shift and every done pulse is matched to the queues.
   always @(negedge config_clk) begin
      if (cfg_shift_en === 1'b1) begin
         check("shift_expected", 32'(bit_q.size() != 0), 1);
         if (bit_q.size() != 0) check("cfg_bit", 32'(cfg_bit), 32'(bit_q.pop_front()));
      end
      if (busy === 1'b1 && cfg_shift_en === 1'b0) gap_cnt++;
      if (done === 1'b1) begin
         check("done_expected", 32'(done_q.size() != 0), 1);
         if (done_q.size() != 0) check("done_cycle", 32'(cyc), 32'(done_q.pop_front()));
      end
   end

   task automatic push_bits(input logic [31:0] w0, input logic [31:0] w1, input int n);
      for (int i = 0; i < n; i++) bit_q.push_back((i < 32) ? w0[i] : w1[i - 32]);
   endtask

   task automatic wait_ready();
      for (int n = 0; n < 100 && word_ready !== 1'b1; n++) tick();
      check("ready_timeout", 32'(word_ready), 1);
   endtask

   task automatic wait_done();
      for (int n = 0; n < 200 && done !== 1'b1; n++) tick();
      check("done_timeout", 32'(done), 1);
   endtask

   // Offer a word once the loader can take it, optionally stalling first.
   task automatic send_word(input logic [31:0] w, input int stall);
      word_valid = 1'b0;
      wait_ready();
      repeat (stall) tick();
      word_data  = w;
      word_valid = 1'b1;
      wait_ready();
      tick();
      word_valid = 1'b0;
   endtask

   task automatic start_load();
      start   = 1'b1;
      gap_cnt = 0;
      tick();
      start = 1'b0;
      check("ready_after_start", 32'(word_ready), 1);
      check("busy_after_start", 32'(busy), 1);
   endtask

   // One complete 36-bit load; returns during the DONE cycle.
   task automatic full_load(input logic [31:0] w0, input logic [31:0] w1, input int stall);
      push_bits(w0, w1, BITS);
      done_q.push_back(cyc + 38 + stall);
      start_load();
      send_word(w0, 0);
      send_word(w1, stall);
      wait_done();
      check("gap_cycles", 32'(gap_cnt), 32'(1 + stall));
      check("ready_in_done", 32'(word_ready), 0);
      check("busy_in_done", 32'(busy), 0);
   endtask

   initial begin
      int            s;
      int            accepts;
      int            nsh;
      int            done_at;
      logic [31:0]   got32;

      // Reset state.
      repeat (3) tick();
      check("rst_word_ready", 32'(word_ready), 0);
      check("rst_cfg_bit", 32'(cfg_bit), 0);
      check("rst_shift_en", 32'(cfg_shift_en), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      config_reset = 1'b0;
      tick();

      // Back-to-back words, no stalls.
      full_load(32'hA5A5_A5A5, 32'h0000_000F, 0);
      tick();
      check("done_one_cycle", 32'(done), 0);
      check("idle_after_done", 32'(busy), 0);

      // Five-cycle stall between words.
      full_load(32'hA5A5_A5A5, 32'h0000_000F, 5);
      tick();

      // start during SHIFT is ignored; start during DONE is ignored.
      fork
         full_load(32'h1234_5678, 32'h0000_0009, 0);
         begin
            repeat (15) tick();
            start = 1'b1;
            tick();
            start = 1'b0;
         end
      join
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_in_done_busy", 32'(busy), 0);
      check("start_in_done_ready", 32'(word_ready), 0);
      tick();
      check("start_in_done_stays_idle", 32'(busy), 0);

      // Abort at the 10th shift, then a fresh full load.
      push_bits(32'hDEAD_BEEF, 32'h0, 10);
      start_load();
      send_word(32'hDEAD_BEEF, 0);
      repeat (9) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_busy", 32'(busy), 0);
      check("abort_ready", 32'(word_ready), 0);
      check("abort_shift_en", 32'(cfg_shift_en), 0);
      check("abort_done", 32'(done), 0);
      repeat (5) tick();
      check("abort_stays_idle", 32'(busy), 0);
      full_load(32'h3C3C_1234, 32'hFFFF_FFF5, 0);
      tick();

      // abort beats start in IDLE.
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      check("abort_wins_busy", 32'(busy), 0);
      check("abort_wins_ready", 32'(word_ready), 0);

      // Reset mid-load: five shifts, then everything returns to zero.
      push_bits(32'h8000_001B, 32'h0, 5);
      start_load();
      send_word(32'h8000_001B, 0);
      repeat (4) tick();
      config_reset = 1'b1;
      tick();
      check("midrst_word_ready", 32'(word_ready), 0);
      check("midrst_cfg_bit", 32'(cfg_bit), 0);
      check("midrst_shift_en", 32'(cfg_shift_en), 0);
      check("midrst_busy", 32'(busy), 0);
      check("midrst_done", 32'(done), 0);
      config_reset = 1'b0;
      tick();
      check("midrst_idle", 32'(busy), 0);

      // 32-bit chain, valid held high: exactly one accept, done at cycle 34.
      accepts = 0;
      nsh     = 0;
      done_at = -1;
      got32   = '0;
      s            = cyc;
      word_data32  = 32'hC0FF_EE11;
      word_valid32 = 1'b1;
      start32      = 1'b1;
      tick();
      start32 = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (ready32 && word_valid32) accepts++;
         if (sen32) begin
            if (nsh < 32) got32[nsh] = bit32;
            nsh++;
         end
         if (done32 && done_at < 0) done_at = cyc - s;
         tick();
      end
      word_valid32 = 1'b0;
      check("c32_accepts", 32'(accepts), 1);
      check("c32_shifts", 32'(nsh), 32);
      check("c32_stream", got32, 32'hC0FF_EE11);
      check("c32_done_cycle", 32'(done_at), 34);
      check("c32_idle", 32'(busy32), 0);

      // Every expected bit and done pulse must have been observed.
      check("bits_drained", 32'(bit_q.size()), 0);
      check("dones_drained", 32'(done_q.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
